// File: rtl/l2_mem_responder.sv
// Main-memory responder for the L2 miss path: line-wide backing store answering refills and
// write-backs after a fixed latency with a one-cycle ready pulse.
module l2_mem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         read_L2_MEM,
    input  logic         write_L2_MEM,
    input  logic [7:0]   index_L2_MEM,
    input  logic [17:0]  tag_L2_MEM,
    input  logic [17:0]  write_tag_L2_MEM,
    input  logic [511:0] write_data_L2_MEM,
    output logic         ready_MEM_L2,
    output logic [511:0] read_data_MEM_L2
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

    state_t              r_state;
    logic   [7:0]        r_cnt;
    logic                r_op_wr;
    logic   [ADDR_W-1:0] r_addr;
    logic   [511:0]      r_wdata;
    logic                r_ready;
    logic   [511:0]      r_rdata;

    // Contents survive rst; only the elaboration-time value is zero.
    logic   [511:0]      r_mem [Depth] = '{default: '0};

    logic                w_commit;
    logic                w_commit_wr;

    assign w_commit    = (r_state == StBusy) && (r_cnt == 8'd0);
    assign w_commit_wr = w_commit && r_op_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (write_L2_MEM) begin
                        r_op_wr <= 1'b1;
                        r_addr  <= ADDR_W'({write_tag_L2_MEM, index_L2_MEM});
                        r_wdata <= write_data_L2_MEM;
                        r_cnt   <= 8'(LATENCY - 1);
                        r_state <= StBusy;
                    end else if (read_L2_MEM) begin
                        r_op_wr <= 1'b0;
                        r_addr  <= ADDR_W'({tag_L2_MEM, index_L2_MEM});
                        r_wdata <= write_data_L2_MEM;
                        r_cnt   <= 8'(LATENCY - 1);
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= StResp;
                        r_ready <= 1'b1;
                        if (!r_op_wr) begin
                            r_rdata <= r_mem[r_addr];
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Gated by rst so a reset landing on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (w_commit_wr && !rst) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign ready_MEM_L2     = r_ready;
    assign read_data_MEM_L2 = r_rdata;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Self-checking bench for l2_mem_responder: timestamp-based reference model plus directed
// transactions with literal expectations; a second instance covers LATENCY=1.
module tb_l2_mem_responder;

    localparam int unsigned Lat   = 4;
    localparam int unsigned AddrW = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd, wr, rd1, wr1;
    logic [7:0]   idx;
    logic [17:0]  tag, wtag;
    logic [511:0] wdata;
    logic         ready, ready1;
    logic [511:0] rdata, rdata1;

    int checks = 0;
    int errors = 0;
    int pulses1 = 0;

    always #5 clk = ~clk;

    l2_mem_responder #(.LATENCY(Lat), .ADDR_W(AddrW)) dut (
        .clk               (clk),
        .rst               (rst),
        .read_L2_MEM       (rd),
        .write_L2_MEM      (wr),
        .index_L2_MEM      (idx),
        .tag_L2_MEM        (tag),
        .write_tag_L2_MEM  (wtag),
        .write_data_L2_MEM (wdata),
        .ready_MEM_L2      (ready),
        .read_data_MEM_L2  (rdata)
    );

    l2_mem_responder #(.LATENCY(1), .ADDR_W(AddrW)) dut1 (
        .clk               (clk),
        .rst               (rst),
        .read_L2_MEM       (rd1),
        .write_L2_MEM      (wr1),
        .index_L2_MEM      (idx),
        .tag_L2_MEM        (tag),
        .write_tag_L2_MEM  (wtag),
        .write_data_L2_MEM (wdata),
        .ready_MEM_L2      (ready1),
        .read_data_MEM_L2  (rdata1)
    );

    // Reference model: each accepted request completes LAT edges later; next accept LAT+2.
    logic [511:0] m_mem [int];
    bit           m_pend = 1'b0;
    bit           m_op_wr;
    int           m_addr;
    logic [511:0] m_data;
    longint       m_done, m_next = 0, edge_n = 0;
    bit           m_exp_ready = 1'b0;
    logic [511:0] m_exp_rdata = '0;

    function automatic int line_addr(input logic [17:0] t, input logic [7:0] i);
        return int'({t, i}) % (2 ** AddrW);
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_pend      = 1'b0;
            m_next      = edge_n + 1;
            m_exp_ready = 1'b0;
            m_exp_rdata = '0;
        end else begin
            m_exp_ready = 1'b0;
            if (m_pend && edge_n == m_done) begin
                m_exp_ready = 1'b1;
                m_pend      = 1'b0;
                if (m_op_wr) m_mem[m_addr] = m_data;
                else m_exp_rdata = m_mem.exists(m_addr) ? m_mem[m_addr] : '0;
            end
            if (!m_pend && edge_n >= m_next && (wr || rd)) begin
                m_pend  = 1'b1;
                m_op_wr = wr;
                m_addr  = wr ? line_addr(wtag, idx) : line_addr(tag, idx);
                m_data  = wdata;
                m_done  = edge_n + Lat;
                m_next  = edge_n + Lat + 2;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic         exp_r;
        logic [511:0] exp_d;
        if (rst) begin
            exp_r = 1'b0;
            exp_d = '0;
        end else begin
            exp_r = m_exp_ready;
            exp_d = m_exp_rdata;
        end
        checks++;
        if (ready !== exp_r) begin
            errors++;
            $display("FAIL model_ready t=%0t act=%b exp=%b", $time, ready, exp_r);
        end
        checks++;
        if (rdata !== exp_d) begin
            errors++;
            $display("FAIL model_rdata t=%0t act=%0h exp=%0h", $time, rdata, exp_d);
        end
        if (ready1) pulses1++;
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Counts edges from the drive point until the selected ready is seen high.
    task automatic wait_ready(input bit sel, output int n);
        bit found = 1'b0;
        n = 0;
        while (!found && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ((sel ? ready1 : ready) === 1'b1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout sel=%0d act=none exp=pulse", sel);
        end
    endtask

    task automatic req(input bit sel, input bit w, input bit r, input logic [17:0] t,
                       input logic [17:0] wt, input logic [7:0] i, input logic [511:0] d,
                       output int n);
        @(posedge clk) #2;
        if (sel) begin wr1 = w; rd1 = r; end
        else begin wr = w; rd = r; end
        tag = t; wtag = wt; idx = i; wdata = d;
        wait_ready(sel, n);
        @(posedge clk) #2;
        wr = 0; rd = 0; wr1 = 0; rd1 = 0;
    endtask

    initial begin
        int n, n2, cnt;
        logic [511:0] a5;
        a5 = {64{8'hA5}};
        rst = 1'b1; rd = 0; wr = 0; rd1 = 0; wr1 = 0;
        idx = '0; tag = '0; wtag = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_ready", 512'(ready), 512'(0));
        chk("reset_rdata", rdata, '0);
        @(posedge clk) #2 rst = 1'b0;

        req(0, 0, 1, 18'h0, 18'h0, 8'h05, '0, n);
        chk("rd0_latency", 512'(n), 512'(5));
        chk("rd0_data", rdata, '0);

        req(0, 1, 0, 18'h0, 18'h1, 8'h10, a5, n);
        chk("wr_a5_latency", 512'(n), 512'(5));
        req(0, 0, 1, 18'h1, 18'h0, 8'h10, '0, n);
        chk("rd_a5_latency", 512'(n), 512'(5));
        chk("rd_a5_data", rdata, a5);

        // Both requests high: write first, then the still-held read.
        @(posedge clk) #2;
        wr = 1; rd = 1; tag = 18'h2; wtag = 18'h2; idx = 8'h30; wdata = 512'h1234;
        wait_ready(0, n);
        chk("both_wr_latency", 512'(n), 512'(5));
        chk("both_wr_keeps_rdata", rdata, a5);
        @(posedge clk) #2 wr = 0;
        wait_ready(0, n2);
        chk("both_total_cycles", 512'(n + 1 + n2), 512'(11));
        chk("both_rd_data", rdata, 512'h1234);
        @(posedge clk) #2 rd = 0;

        req(0, 1, 0, 18'h0, 18'h4, 8'h00, 512'hBEEF, n);
        req(0, 0, 1, 18'h0, 18'h0, 8'h00, '0, n);
        chk("alias_data", rdata, 512'hBEEF);

        // Reset asserted in cycle 3 of a write.
        @(posedge clk) #2;
        wr = 1; wtag = 18'h0; idx = 8'h20; wdata = 512'hFF;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", 512'(ready), 512'(0));
        chk("async_rst_rdata", rdata, '0);
        @(posedge clk) #2;
        rst = 1'b0; wr = 0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        chk("rst_no_pulse", 512'(cnt), 512'(0));
        req(0, 0, 1, 18'h0, 18'h0, 8'h20, '0, n);
        chk("rst_dropped_write", rdata, '0);

        pulses1 = 0;
        req(1, 1, 0, 18'h0, 18'h0, 8'h09, 512'h77, n);
        chk("lat1_wr_latency", 512'(n), 512'(2));
        req(1, 0, 1, 18'h0, 18'h0, 8'h09, '0, n);
        chk("lat1_rd_latency", 512'(n), 512'(2));
        chk("lat1_rd_data", rdata1, 512'h77);
        repeat (10) @(posedge clk);
        #2;
        chk("lat1_pulse_count", 512'(pulses1), 512'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
